// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames a loaded byte with start, optional parity
// and stop bits and shifts it out LSB-first at a programmable bit rate.
module uart_tx_engine #(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic              load,
    input  logic [7:0]        out_port,
    output logic              tx,
    output logic              txrdy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BAUD_W-1:0] k_q, k_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              eight_q, eight_d;
    logic              pen_q, pen_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              rdy_q, rdy_d;

    logic [BAUD_W-1:0] k_eff;
    logic [3:0]        last_bit;
    logic              bit_end;

    // A divisor of zero behaves like one clock per bit.
    assign k_eff    = (baud_k == '0) ? BAUD_W'(1) : baud_k;
    assign last_bit = eight_q ? 4'd7 : 4'd6;
    assign bit_end  = (cnt_q == k_q - BAUD_W'(1));

    assign tx    = tx_q;
    assign txrdy = rdy_q;

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            bit_q   <= '0;
            sh_q    <= 8'hFF;
            eight_q <= 1'b1;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: each bit lasts k_q clocks, tx is set a bit ahead.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sh_d    = out_port;
                    k_d     = k_eff;
                    eight_d = eight;
                    pen_d   = pen;
                    par_d   = (eight ? ^out_port : ^out_port[6:0]) ^ ohel;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end else begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b1, sh_q[7:1]};
                    state_d = DATA;
                end
            end
            DATA: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q == last_bit) begin
                        if (pen_q) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b1, sh_q[7:1]};
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end else begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end else begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: checks every clock of several
// frames, busy/late loads, async mid-frame reset and divisor 0/1.
module tb_uart_tx_engine;

    logic        clk;
    logic        reset;
    logic [19:0] baud_k;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        load;
    logic [7:0]  out_port;
    logic        tx;
    logic        txrdy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_engine #(.BAUD_W(20)) dut (
        .clk      (clk),
        .reset    (reset),
        .baud_k   (baud_k),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .load     (load),
        .out_port (out_port),
        .tx       (tx),
        .txrdy    (txrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // s lists the expected tx level per bit in transmit order.
    // busy_at: clock index at which a stray load (with altered config)
    // is pulsed; abort_at: clock index at which reset is dropped.
    task automatic run_frame(input string tag, input logic [7:0] d,
                             input logic e, input logic p,
                             input logic o, input logic [19:0] k,
                             input string s, input int busy_at,
                             input int abort_at);
        int kk;
        int f;
        kk = (k == 0) ? 1 : int'(k);
        f  = s.len();
        @(negedge clk);
        out_port = d;
        eight    = e;
        pen      = p;
        ohel     = o;
        baud_k   = k;
        load     = 1'b1;
        for (int c = 0; c < f * kk; c++) begin
            @(negedge clk);
            load = (c == busy_at);
            if (c == busy_at) begin
                out_port = ~d;
                eight    = ~e;
                pen      = ~p;
                ohel     = ~o;
                baud_k   = k + 20'd3;
            end
            check({tag, " tx"}, tx, (s[c / kk] == "1"));
            check({tag, " txrdy busy"}, txrdy, 0);
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                check({tag, " abort tx"}, tx, 1);
                check({tag, " abort txrdy"}, txrdy, 1);
                @(negedge clk);
                check({tag, " rst hold tx"}, tx, 1);
                check({tag, " rst hold txrdy"}, txrdy, 1);
                reset = 1'b1;
                @(negedge clk);
                check({tag, " post rst tx"}, tx, 1);
                check({tag, " post rst txrdy"}, txrdy, 1);
                return;
            end
        end
        @(negedge clk);
        load = 1'b0;
        check({tag, " txrdy end"}, txrdy, 1);
        check({tag, " tx end"}, tx, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, " idle tx"}, tx, 1);
            check({tag, " idle txrdy"}, txrdy, 1);
        end
    endtask

    initial begin
        reset    = 1'b0;
        baud_k   = 20'd4;
        eight    = 1'b1;
        pen      = 1'b0;
        ohel     = 1'b0;
        load     = 1'b0;
        out_port = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset txrdy", txrdy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("idle tx", tx, 1);
        check("idle txrdy", txrdy, 1);

        run_frame("8N1 A5", 8'hA5, 1, 0, 0, 20'd4, "0101001011", -1, -1);
        run_frame("7E1 41", 8'h41, 0, 1, 0, 20'd3, "0100000101", -1, -1);
        run_frame("8O1 FF", 8'hFF, 1, 1, 1, 20'd2, "01111111111", -1, -1);
        run_frame("busy 00", 8'h00, 1, 0, 0, 20'd4, "0000000001", 10, -1);
        run_frame("late ld", 8'hA5, 1, 0, 0, 20'd4, "0101001011", 39, -1);
        run_frame("abort", 8'hA5, 1, 0, 0, 20'd4, "0101001011", -1, 17);
        run_frame("after rst 3C", 8'h3C, 1, 0, 0, 20'd4, "0001111001", -1, -1);
        run_frame("k0 01", 8'h01, 1, 0, 0, 20'd0, "0100000001", -1, -1);
        run_frame("k1 01", 8'h01, 1, 0, 0, 20'd1, "0100000001", -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
